input_sched: RTL and testbench
==============================

# input_sched

Round-robin scheduler that shares the single 32-bit input sample stream among the NCORES processing cores of the multicore array. Each core raises a request code when it needs one or two samples. The scheduler latches the requests, picks one core at a time in round-robin order, and moves the requested number of samples from the source onto a broadcast data bus with a one-hot grant. It sits between the sample source (file reader or ADC front end) and the `in`/`req_in` ports of the multicore top.

## Interface
Parameters:
- NCORES, 48, number of requesting cores
- DW, 32, sample width (signed two's complement, passed through unmodified)

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_data  in  DW  sample offered by the source
- src_valid  in  1  src_data is valid this cycle
- src_ready  out  1  scheduler accepts src_data this cycle
- req_in  in  2*NCORES  per-core request code, core i at bits [2i+1:2i]
- core_data  out  DW  registered broadcast sample for the granted core
- grant  out  NCORES  registered one-hot grant, one cycle per delivered sample
- busy  out  1  state is XFER or any pending request is nonzero
- err_overrun  out  1  sticky flag: a request arrived while that core already had one pending

## Operation
- Request codes:
  - 00 = none
  - 01 = one sample
  - 10 = two-sample burst (I/Q pair)
  - 11 = treated as 01
- Pending array: pend[i] is 2 bits and holds the outstanding request count (0, 1 or 2).
- Request capture, on each edge where req_in[i] != 0:
  - if pend[i] == 0, or pend[i] is being cleared by a pick on this same edge, pend[i] takes the new count (set has priority over clear);
  - otherwise pend[i] is unchanged and err_overrun is set to 1 until reset.
- Round-robin pointer ptr holds the last served core. The search starts at ptr+1 and wraps modulo NCORES; the first core with pend != 0 wins.
- FSM states: IDLE, XFER.
  - IDLE:
    - src_ready = 0.
    - If any pend != 0: owner is set to the winner, cnt is set to pend[winner], pend[winner] is cleared, and the FSM goes to XFER.
    - Otherwise it stays in IDLE.
  - XFER:
    - src_ready = 1.
    - On a cycle with src_valid = 1: core_data is loaded with src_data, grant is loaded with the one-hot of owner, and cnt is decremented.
    - If cnt was 1: ptr is set to owner and the FSM returns to IDLE.
    - If src_valid = 0: no transfer, grant = 0, state and cnt are held.
- A burst is never interrupted. Requests from other cores wait in pend.
- grant is all-zero on every cycle without a transfer. core_data holds its last value.
- src_ready is a combinational decode of the state only. It never depends on src_valid.

## Timing
- Reset values:
  - state = IDLE
  - ptr = NCORES-1 (core 0 has first priority)
  - pend = 0, owner = 0, cnt = 0
  - core_data = 0, grant = 0
  - src_ready = 0, busy = 0, err_overrun = 0
- Reset asserted mid-burst aborts the burst. Remaining samples are dropped and no grant is issued after rst_n rises until a new request arrives.
- Request latency: req_in sampled at edge k sets pend at edge k. The pick happens at edge k+1. src_ready is high from after edge k+1. The earliest grant and core_data are visible after edge k+2.
- Throughput:
  - one IDLE cycle per burst;
  - back-to-back single requests give one sample every 2 cycles;
  - 2-sample bursts give 2 samples every 3 cycles.
- A transfer occurs exactly when src_valid && src_ready at a rising edge. Each accepted sample produces exactly one grant pulse, on the following cycle.
- Wrap-around: if ptr = NCORES-1, the search starts at core 0. A single active core is re-picked every burst.
- Simultaneous requests from all cores are served in the order ptr+1 ... ptr+NCORES, each exactly once.

## Test plan
- After reset, single request: req_in core 5 = 01 for one cycle, src_valid held 1 with src_data = -7.
  - Required: exactly one grant pulse with grant[5]=1 and core_data = -7, 2 cycles after the request edge. src_ready then drops.
- All-core contention: all 48 cores request 01 on the same cycle, and the source supplies 0,1,2,...
  - Required: grants in order core 0..47, core i receives value i, 96 cycles total, busy deasserts afterwards.
- Burst with stalled source: core 3 = 10 and core 4 = 01 on the same cycle, src_valid toggling 1,0,1.
  - Required: two grants to core 3 with no grant during the stall cycle, then one grant to core 4. Core 4 is never granted inside core 3's burst.
- Overrun: core 7 requests 01, then requests 01 again before it is picked.
  - Required: err_overrun = 1 and held, and core 7 receives only one sample.
- Re-request from owner: core 9 requests 01 on the same edge it is picked.
  - Required: pend[9] = 1 afterwards, core 9 receives 2 samples in total, and err_overrun stays 0.
- Reset mid-burst: core 2 = 10, rst_n pulsed low after the first grant.
  - Required: all outputs at reset values immediately, and no second grant to core 2.

Source files
------------

// File: rtl/input_sched.sv
// Purpose: round-robin scheduler sharing one DW-bit sample stream among NCORES cores (1- or 2-sample requests).
// Latency: request edge k -> pick at edge k+1 -> first grant/core_data visible after edge k+2; one IDLE cycle per burst.
// Backpressure: src_ready is high only while a burst is in flight; src_valid=0 stalls the burst, other requests wait in pend.
module input_sched #(
  parameter int NCORES = 48,
  parameter int DW     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       src_data,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [2*NCORES-1:0] req_in,
  output logic [DW-1:0]       core_data,
  output logic [NCORES-1:0]   grant,
  output logic                busy,
  output logic                err_overrun
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      winner;
  logic [1:0]         cnt;
  logic [1:0]         pend [NCORES];
  logic               any_pend;
  logic               win_found;
  logic               do_pick;
  logic               do_xfer;
  logic               last_xfer;
  logic [NCORES-1:0]  pick_clr;
  logic [NCORES-1:0]  owner_onehot;
  int                 j;

  // Any core with an outstanding request
  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (pend[i] != 2'd0) any_pend = 1'b1;
    end
  end

  // Round-robin search: first pending core after the last served one, wrapping
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    j         = 0;
    for (int k = 1; k <= NCORES; k++) begin
      j = int'(ptr) + k;
      if (j >= NCORES) j = j - NCORES;
      if (!win_found && pend[j] != 2'd0) begin
        winner    = j[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Per-core clear strobe for the core picked on this edge
  always_comb begin
    pick_clr = '0;
    for (int i = 0; i < NCORES; i++) begin
      pick_clr[i] = do_pick && (winner == i[PW-1:0]);
    end
  end

  assign owner_onehot = {{(NCORES-1){1'b0}}, 1'b1} << owner;
  assign busy         = (state == XFER) || any_pend;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and control strobes; src_ready depends on state only
  always_comb begin
    state_nxt = state;
    src_ready = 1'b0;
    do_pick   = 1'b0;
    do_xfer   = 1'b0;
    last_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          do_pick   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        src_ready = 1'b1;
        if (src_valid) begin
          do_xfer = 1'b1;
          if (cnt == 2'd1) begin
            last_xfer = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping and registered broadcast outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PW'(NCORES-1);
      owner     <= '0;
      cnt       <= 2'd0;
      core_data <= '0;
      grant     <= '0;
    end else begin
      grant <= '0;
      if (do_pick) begin
        owner <= winner;
        cnt   <= pend[winner];
      end
      if (do_xfer) begin
        core_data <= src_data;
        grant     <= owner_onehot;
        cnt       <= cnt - 2'd1;
        if (last_xfer) ptr <= owner;
      end
    end
  end

  // Request capture: a new request wins over the pick clear; a collision is a sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCORES; i++) pend[i] <= 2'd0;
      err_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (req_in[2*i +: 2] != 2'b00) begin
          if (pend[i] == 2'd0 || pick_clr[i]) begin
            pend[i] <= (req_in[2*i +: 2] == 2'b10) ? 2'd2 : 2'd1;
          end else begin
            err_overrun <= 1'b1;
          end
        end else if (pick_clr[i]) begin
          pend[i] <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_sched.sv
// Bench for input_sched: directed scenarios with literal expectations plus randomized traffic.
// A queue/array reference model predicts grant, core_data, src_ready, busy and err_overrun each cycle.
// Inputs change 2 time units after the rising edge; the model updates on the rising edge, outputs are compared on the falling edge.
module tb_input_sched;
  localparam int N  = 48;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DW-1:0]   src_data;
  logic            src_valid;
  logic            src_ready;
  logic [2*N-1:0]  req_in;
  logic [DW-1:0]   core_data;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err_overrun;

  always #5 clk = ~clk;

  input_sched #(.NCORES(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .req_in(req_in), .core_data(core_data), .grant(grant),
    .busy(busy), .err_overrun(err_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int           obs_core[$];
  logic [DW-1:0] obs_data[$];
  int           obs_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: outstanding counts per core, last-served pointer, current burst owner and samples left
  int            m_pend[N];
  int            m_ptr = N-1;
  int            m_own = 0;
  int            m_rem = 0;
  int            m_gcore = -1;
  bit            m_err = 1'b0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = N-1; m_own = 0; m_rem = 0; m_gcore = -1; m_err = 1'b0; m_data = '0;
    end else begin
      int old[N];
      int picked;
      old = m_pend;
      picked = -1;
      m_gcore = -1;
      if (m_rem > 0) begin
        if (src_valid) begin
          m_data  = src_data;
          m_gcore = m_own;
          m_rem   = m_rem - 1;
          if (m_rem == 0) m_ptr = m_own;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (picked < 0 && old[c] > 0) picked = c;
        end
        if (picked >= 0) begin
          m_own = picked;
          m_rem = old[picked];
        end
      end
      for (int i = 0; i < N; i++) begin
        logic [1:0] code;
        code = req_in[2*i +: 2];
        if (code != 2'b00) begin
          if (old[i] == 0 || i == picked) m_pend[i] = (code == 2'b10) ? 2 : 1;
          else m_err = 1'b1;
        end else if (i == picked) begin
          m_pend[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, and a log of every observed grant
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] one;
    bit eb;
    int gi;
    one = 1;
    eg  = (m_gcore >= 0) ? (one << m_gcore) : '0;
    eb  = (m_rem > 0);
    for (int i = 0; i < N; i++) if (m_pend[i] > 0) eb = 1'b1;
    check("cmp_grant",     grant,       eg);
    check("cmp_core_data", core_data,   m_data);
    check("cmp_src_ready", src_ready,   (m_rem > 0));
    check("cmp_busy",      busy,        eb);
    check("cmp_err",       err_overrun, m_err);
    if (grant != '0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (grant[i] && gi < 0) gi = i;
      obs_core.push_back(gi);
      obs_data.push_back(core_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_in = '0; src_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_core.delete(); obs_data.delete(); obs_cyc.delete();
  endtask

  task automatic set_req(input int core, input logic [1:0] code);
    req_in[2*core +: 2] = code;
  endtask

  bit   vt[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int   t0;
  int   sent;
  int   cnt9;
  logic r;

  initial begin
    src_data = '0; src_valid = 1'b0; req_in = '0;
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_grant",     grant,       0);
    check("rst_core_data", core_data,   0);
    check("rst_src_ready", src_ready,   0);
    check("rst_busy",      busy,        0);
    check("rst_err",       err_overrun, 0);
    rst_n = 1'b1;
    step();

    // Single request from core 5, sample -7
    clear_obs();
    set_req(5, 2'b01); src_valid = 1'b1; src_data = -7;
    step(); req_in = '0;
    check("t1_ready_after_req", src_ready, 0);
    check("t1_busy_after_req",  busy, 1);
    step();
    check("t1_ready_after_pick", src_ready, 1);
    check("t1_no_grant_yet",     grant, 0);
    step();
    check("t1_grant",      grant, 48'h20);
    check("t1_core_data",  core_data, 32'hFFFF_FFF9);
    check("t1_model_core", m_gcore, 5);
    check("t1_model_data", m_data, 32'hFFFF_FFF9);
    check("t1_ready_drop", src_ready, 0);
    step();
    check("t1_grant_clear", grant, 0);
    check("t1_one_grant",   obs_core.size(), 1);
    check("t1_busy_done",   busy, 0);

    // All 48 cores request one sample; source counts 0,1,2,...
    do_reset(); clear_obs();
    for (int i = 0; i < N; i++) set_req(i, 2'b01);
    src_valid = 1'b1; src_data = '0; sent = 0;
    step(); req_in = '0; t0 = cyc;
    for (int c = 0; c < 300; c++) begin
      if (!busy) break;
      r = src_ready;
      step();
      if (r) sent++;
      src_data = DW'(sent);
    end
    check("t2_busy_done", busy, 0);
    step();
    check("t2_count", obs_core.size(), N);
    for (int i = 0; i < N && i < obs_core.size(); i++) begin
      check("t2_order", obs_core[i], i);
      check("t2_value", obs_data[i], i);
    end
    if (obs_cyc.size() == N) begin
      check("t2_first_latency", obs_cyc[0] - t0, 2);
      check("t2_total_cycles",  obs_cyc[N-1] - t0, 96);
    end

    // Core 3 burst of two with a stalled source, core 4 single
    do_reset(); clear_obs();
    src_valid = 1'b1; src_data = 32'd100;
    set_req(3, 2'b10); set_req(4, 2'b01);
    step(); req_in = '0; t0 = cyc;
    for (int jj = 1; jj <= 7; jj++) begin
      src_valid = vt[jj-1];
      src_data  = 32'd100 + 32'(jj);
      step();
    end
    step();
    check("t3_count", obs_core.size(), 3);
    if (obs_core.size() == 3) begin
      check("t3_core0", obs_core[0], 3);
      check("t3_core1", obs_core[1], 3);
      check("t3_core2", obs_core[2], 4);
      check("t3_data0", obs_data[0], 102);
      check("t3_data1", obs_data[1], 104);
      check("t3_data2", obs_data[2], 106);
      check("t3_stall_gap", obs_cyc[1] - obs_cyc[0], 2);
      check("t3_core4_time", obs_cyc[2] - t0, 6);
    end

    // Overrun: core 7 re-requests while core 6 is being picked
    do_reset(); clear_obs();
    src_valid = 1'b1; src_data = 32'd55;
    set_req(6, 2'b01); set_req(7, 2'b01);
    step(); req_in = '0; set_req(7, 2'b01);
    step(); req_in = '0;
    check("t4_err_set", err_overrun, 1);
    repeat (6) step();
    check("t4_err_held", err_overrun, 1);
    check("t4_count", obs_core.size(), 2);
    if (obs_core.size() == 2) begin
      check("t4_first",  obs_core[0], 6);
      check("t4_second", obs_core[1], 7);
    end

    // Core 9 re-requests on the edge it is picked
    do_reset(); clear_obs();
    src_valid = 1'b1; src_data = 32'd77;
    set_req(9, 2'b01);
    step();
    step(); req_in = '0;
    check("t5_busy_xfer", busy, 1);
    step();
    check("t5_grant",      grant, 48'h200);
    check("t5_busy_pend",  busy, 1);
    check("t5_ready_idle", src_ready, 0);
    repeat (4) step();
    cnt9 = 0;
    foreach (obs_core[q]) if (obs_core[q] == 9) cnt9++;
    check("t5_two_samples", cnt9, 2);
    check("t5_total",       obs_core.size(), 2);
    check("t5_no_err",      err_overrun, 0);
    check("t5_busy_done",   busy, 0);

    // Reset in the middle of core 2's burst
    do_reset(); clear_obs();
    src_valid = 1'b1; src_data = 32'd33;
    set_req(2, 2'b10);
    step(); req_in = '0;
    step(); step();
    check("t6_first_grant", grant, 48'h4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant,       0);
    check("t6_rst_data",  core_data,   0);
    check("t6_rst_ready", src_ready,   0);
    check("t6_rst_busy",  busy,        0);
    check("t6_rst_err",   err_overrun, 0);
    step(); rst_n = 1'b1;
    repeat (6) step();
    check("t6_no_more_grants", obs_core.size(), 0);
    check("t6_busy_idle",      busy, 0);

    // Randomized traffic, occasional all-core storms and reset pulses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_in = '0;
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < N; i++) req_in[2*i +: 2] = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 31) == 0) req_in[2*i +: 2] = 2'($urandom_range(1, 3));
      end
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = $urandom;
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; req_in = '0; src_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!busy) break;
      step();
    end
    check("rand_drain", busy, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
